dram_bank_sched: RTL
====================

// Module: dram_bank_sched
// PURPOSE
// - Cycle-accurate, parametrised DRAM command scheduler; one request in flight at a time.
// - Tracks an open row per bank across NUM_BG x NUM_BA banks and classifies each request as HIT, MISS or EMPTY.
// - Issues PRE/ACT/RD/WR commands while enforcing tRCD, tRP, tRAS, tCL, tCWD, tBURST, tWR, tRRD_S/L and tCCD_S/L.
// - Sits between the request queue and the trace/command printer. Supports open-page and closed-page modes.
// PARAMETERS
// NUM_BG      4   bank groups (power of 2)
// NUM_BA      4   banks per group (power of 2)
// ROW_W       15  row address width
// COL_W       11  column address width
// CLOSED_PAGE 0   0 = open page; 1 = auto-precharge after every access
// TRCD=24 TRP=24 TRAS=52 TCL=24 TCWD=20 TBURST=4 TWR=20 TRRD_S=4 TRRD_L=6 TCCD_S=4 TCCD_L=8  (all in clk cycles)
// PORTS
// clk         in   1      DRAM command clock
// rst         in   1      synchronous, active-high reset
// req_valid   in   1      request present
// req_ready   out  1      block can accept a request
// req_rd_wr   in   1      0 = read, 1 = write
// req_bg      in   $clog2(NUM_BG)  bank group
// req_bank    in   $clog2(NUM_BA)  bank
// req_row     in   ROW_W  row
// req_col     in   COL_W  column
// cmd_valid   out  1      one-cycle pulse: command issued this cycle
// cmd_type    out  3      0 NOP, 1 PRE, 2 ACT, 3 RD, 4 WR
// cmd_bg/cmd_bank/cmd_row/cmd_col  out  as req  command address; latched request fields
// done        out  1      one-cycle pulse at last data beat
// done_policy out  2      0 HIT, 1 MISS, 2 EMPTY; valid only while done=1
// BEHAVIOUR
// - Reset
//   - All outputs are 0 except req_ready, which is 1 in the cycle after rst deasserts.
//   - All banks are closed; all timers are saturated (no pending constraints).
//   - rst mid-operation abandons the request; no done pulse is generated.
// - Accept
//   - A request is accepted when req_valid && req_ready at a rising edge (cycle A).
//   - req_ready drops the next cycle and stays low until the block returns to IDLE.
// - Classification at A
//   - EMPTY: the target bank is closed.
//   - HIT: the bank is open with a matching row.
//   - MISS: the bank is open with a different row.
// - FSM: IDLE -> {PRE_W, ACT_W, RW_W} -> DATA -> (CLOSED_PAGE ? CPRE_W : IDLE) -> IDLE.
//   - PRE_W issues PRE when both hold:
//     - cycles since this bank's ACT >= TRAS;
//     - cycles since end of the last write data to this bank >= TWR.
//   - PRE closes the bank.
//   - ACT_W issues ACT when both hold:
//     - cycles since PRE to this bank >= TRP;
//     - cycles since the last ACT in any bank >= TRRD_L (same BG) or TRRD_S (other BG).
//   - ACT opens the row.
//   - RW_W issues RD/WR when both hold:
//     - cycles since this bank's ACT >= TRCD;
//     - cycles since the last RD/WR >= TCCD_L (same BG) or TCCD_S (other BG).
//   - DATA counts TCL+TBURST cycles (read) or TCWD+TBURST cycles (write) from the RD/WR cycle.
//     - done pulses on the final count.
//   - CPRE_W issues PRE under the PRE_W rules, then returns to IDLE.
// - Earliest issue of any command is A+1; at most one command per cycle.
// - Every cycle that is not an issue cycle drives cmd_valid=0 and cmd_type=NOP.
// - Timers are saturating 8-bit counters and never wrap.
//   - Per bank: since ACT, since PRE, since write end.
//   - Global: since ACT, since RD/WR; the BG of the last ACT and last RD/WR is also held.
// - Timing values above 255 are illegal; an elaboration assertion rejects them.
// - A request arriving while busy is held off by req_ready=0; it is never dropped.
// TESTING
// - After reset, EMPTY read BG0/BA0/row 5, accepted at cycle 0:
//   - ACT@1, RD@25, done@53, policy EMPTY.
// - HIT read to the same row, accepted at 54:
//   - RD@55, done@83, policy HIT, no PRE/ACT issued.
// - MISS write to BG0/BA0/row 9 after the HIT:
//   - PRE at the first cycle with tRAS met, ACT at PRE+24, WR at ACT+24, done at WR+24.
// - Back-to-back EMPTY reads to BG0/BA1 then BG1/BA0:
//   - ACT-to-ACT spacing >= 6, then >= 4.
//   - RD-to-RD spacing >= 8 (same BG) and >= 4 (other BG).
// - CLOSED_PAGE=1, write:
//   - PRE issued exactly TWR after write data end; the next request to the same row is classified EMPTY.
// - rst asserted between ACT and RD:
//   - No RD issued, no done pulse; req_ready=1 the cycle after rst drops; all banks closed.

Source files
------------

// File: rtl/dram_bank_sched.sv
// DRAM command scheduler: one request in flight, per-bank open-row tracking,
// PRE/ACT/RD/WR issue under saturating 8-bit timing counters.
module dram_bank_sched #(
    parameter int unsigned NUM_BG      = 4,
    parameter int unsigned NUM_BA      = 4,
    parameter int unsigned ROW_W       = 15,
    parameter int unsigned COL_W       = 11,
    parameter bit          CLOSED_PAGE = 1'b0,
    parameter int unsigned TRCD        = 24,
    parameter int unsigned TRP         = 24,
    parameter int unsigned TRAS        = 52,
    parameter int unsigned TCL         = 24,
    parameter int unsigned TCWD        = 20,
    parameter int unsigned TBURST      = 4,
    parameter int unsigned TWR         = 20,
    parameter int unsigned TRRD_S      = 4,
    parameter int unsigned TRRD_L      = 6,
    parameter int unsigned TCCD_S      = 4,
    parameter int unsigned TCCD_L      = 8,
    localparam int unsigned BG_W       = $clog2(NUM_BG),
    localparam int unsigned BA_W       = $clog2(NUM_BA)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rd_wr,
    input  logic [BG_W-1:0]  req_bg,
    input  logic [BA_W-1:0]  req_bank,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    output logic             cmd_valid,
    output logic [2:0]       cmd_type,
    output logic [BG_W-1:0]  cmd_bg,
    output logic [BA_W-1:0]  cmd_bank,
    output logic [ROW_W-1:0] cmd_row,
    output logic [COL_W-1:0] cmd_col,
    output logic             done,
    output logic [1:0]       done_policy
);

    localparam int unsigned NB     = NUM_BG * NUM_BA;
    localparam int unsigned BK_W   = BG_W + BA_W;
    localparam int unsigned DLEN_W = 9;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_PRE = 3'd1;
    localparam logic [2:0] CMD_ACT = 3'd2;
    localparam logic [2:0] CMD_RD  = 3'd3;
    localparam logic [2:0] CMD_WR  = 3'd4;

    localparam logic [1:0] POL_HIT   = 2'd0;
    localparam logic [1:0] POL_MISS  = 2'd1;
    localparam logic [1:0] POL_EMPTY = 2'd2;

    // Timers are 8 bits wide; larger timing values cannot be represented.
    if (TRCD > 255 || TRP > 255 || TRAS > 255 || TCL > 255 || TCWD > 255 ||
        TBURST > 255 || TWR > 255 || TRRD_S > 255 || TRRD_L > 255 ||
        TCCD_S > 255 || TCCD_L > 255 || TBURST == 0) begin : g_bad_timing
        $error("dram_bank_sched: timing parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_W, S_ACT_W, S_RW_W, S_DATA, S_CPRE_W
    } state_t;

    state_t              state_q;
    logic                rd_wr_q;
    logic [1:0]          policy_q;
    logic [DLEN_W-1:0]   data_cnt_q;
    logic [7:0]          g_act_q, g_rw_q;
    logic [BG_W-1:0]     g_act_bg_q, g_rw_bg_q;
    logic                bank_open_q [NB];
    logic [ROW_W-1:0]    bank_row_q  [NB];
    logic [7:0]          t_act_q     [NB];
    logic [7:0]          t_pre_q     [NB];
    logic [7:0]          t_wr_q      [NB];

    logic [BK_W-1:0]     req_idx_c, cur_idx_c;
    logic                pre_ok_c, act_ok_c, rw_ok_c;
    logic [DLEN_W-1:0]   data_len_c;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Issue-eligibility checks against the latched target bank
    always_comb begin
        req_idx_c  = {req_bg, req_bank};
        cur_idx_c  = {cmd_bg, cmd_bank};
        pre_ok_c   = (t_act_q[cur_idx_c] >= 8'(TRAS)) && (t_wr_q[cur_idx_c] >= 8'(TWR));
        act_ok_c   = (t_pre_q[cur_idx_c] >= 8'(TRP)) &&
                     (g_act_q >= ((cmd_bg == g_act_bg_q) ? 8'(TRRD_L) : 8'(TRRD_S)));
        rw_ok_c    = (t_act_q[cur_idx_c] >= 8'(TRCD)) &&
                     (g_rw_q >= ((cmd_bg == g_rw_bg_q) ? 8'(TCCD_L) : 8'(TCCD_S)));
        data_len_c = rd_wr_q ? DLEN_W'(TCWD + TBURST) : DLEN_W'(TCL + TBURST);
    end

    // Scheduler FSM, bank state and timers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready   <= 1'b1;
            cmd_valid   <= 1'b0;
            cmd_type    <= CMD_NOP;
            cmd_bg      <= '0;
            cmd_bank    <= '0;
            cmd_row     <= '0;
            cmd_col     <= '0;
            done        <= 1'b0;
            done_policy <= POL_HIT;
            rd_wr_q     <= 1'b0;
            policy_q    <= POL_HIT;
            data_cnt_q  <= '0;
            g_act_q     <= 8'hFF;
            g_rw_q      <= 8'hFF;
            g_act_bg_q  <= '0;
            g_rw_bg_q   <= '0;
            for (int b = 0; b < NB; b++) begin
                bank_open_q[b] <= 1'b0;
                bank_row_q[b]  <= '0;
                t_act_q[b]     <= 8'hFF;
                t_pre_q[b]     <= 8'hFF;
                t_wr_q[b]      <= 8'hFF;
            end
        end else begin
            cmd_valid   <= 1'b0;
            cmd_type    <= CMD_NOP;
            done        <= 1'b0;
            done_policy <= POL_HIT;
            g_act_q     <= sat_inc(g_act_q);
            g_rw_q      <= sat_inc(g_rw_q);
            for (int b = 0; b < NB; b++) begin
                t_act_q[b] <= sat_inc(t_act_q[b]);
                t_pre_q[b] <= sat_inc(t_pre_q[b]);
                t_wr_q[b]  <= sat_inc(t_wr_q[b]);
            end

            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        rd_wr_q   <= req_rd_wr;
                        cmd_bg    <= req_bg;
                        cmd_bank  <= req_bank;
                        cmd_row   <= req_row;
                        cmd_col   <= req_col;
                        if (!bank_open_q[req_idx_c]) begin
                            policy_q <= POL_EMPTY;
                            state_q  <= S_ACT_W;
                        end else if (bank_row_q[req_idx_c] == req_row) begin
                            policy_q <= POL_HIT;
                            state_q  <= S_RW_W;
                        end else begin
                            policy_q <= POL_MISS;
                            state_q  <= S_PRE_W;
                        end
                    end
                end
                S_PRE_W, S_CPRE_W: begin
                    if (pre_ok_c) begin
                        cmd_valid              <= 1'b1;
                        cmd_type               <= CMD_PRE;
                        bank_open_q[cur_idx_c] <= 1'b0;
                        t_pre_q[cur_idx_c]     <= 8'd1;
                        if (state_q == S_PRE_W) begin
                            state_q <= S_ACT_W;
                        end else begin
                            state_q   <= S_IDLE;
                            req_ready <= 1'b1;
                        end
                    end
                end
                S_ACT_W: begin
                    if (act_ok_c) begin
                        cmd_valid              <= 1'b1;
                        cmd_type               <= CMD_ACT;
                        bank_open_q[cur_idx_c] <= 1'b1;
                        bank_row_q[cur_idx_c]  <= cmd_row;
                        t_act_q[cur_idx_c]     <= 8'd1;
                        g_act_q                <= 8'd1;
                        g_act_bg_q             <= cmd_bg;
                        state_q                <= S_RW_W;
                    end
                end
                S_RW_W: begin
                    if (rw_ok_c) begin
                        cmd_valid  <= 1'b1;
                        cmd_type   <= rd_wr_q ? CMD_WR : CMD_RD;
                        g_rw_q     <= 8'd1;
                        g_rw_bg_q  <= cmd_bg;
                        data_cnt_q <= DLEN_W'(1);
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (data_cnt_q == data_len_c) begin
                        done        <= 1'b1;
                        done_policy <= policy_q;
                        if (rd_wr_q) begin
                            t_wr_q[cur_idx_c] <= 8'd1;
                        end
                        if (CLOSED_PAGE) begin
                            state_q <= S_CPRE_W;
                        end else begin
                            state_q   <= S_IDLE;
                            req_ready <= 1'b1;
                        end
                    end else begin
                        data_cnt_q <= data_cnt_q + DLEN_W'(1);
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
